// File: rtl/dmem_pkg.sv
// Shared encodings and types for the synchronous byte-addressed data memory.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Read formatter: selects byte/half/word from four raw little-endian bytes and extends to 32 bits.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            zero_ext,
    input  logic [3:0][7:0] raw,
    output logic [31:0]     result
);

    logic byte_fill;
    logic half_fill;

    assign byte_fill = ~zero_ext & raw[0][7];
    assign half_fill = ~zero_ext & raw[1][7];

    always_comb begin
        result = {raw[3], raw[2], raw[1], raw[0]};
        case (size)
            SIZE_BYTE: result = {{24{byte_fill}}, raw[0]};
            SIZE_HALF: result = {{16{half_fill}}, raw[1], raw[0]};
            default:   result = {raw[3], raw[2], raw[1], raw[0]};
        endcase
    end

endmodule

// File: rtl/data_memory_sync.sv
// Clocked byte-addressed data memory with req/ready/valid handshake and configurable latency.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [7:0] mem [DEPTH];

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               we_reg;
    logic [1:0]         size_reg;
    logic               zext_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        wdata_reg;
    logic               valid_reg;
    logic [31:0]        rdata_reg;

    logic               accept;
    logic               finish;
    logic               misaligned;
    logic [3:0]         lane_en;
    logic [3:0][7:0]    raw_bytes;
    logic [ADDR_W-1:0]  lane_addr [4];
    logic [31:0]        fmt_data;
    logic               unused_addr_bits;

    assign accept           = (state_reg == IDLE) && req_i;
    assign finish           = (state_reg == DONE);
    assign unused_addr_bits = ^addr_i[31:ADDR_W];

    // Each lane wraps independently so accesses straddling the top continue at address 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi] = addr_reg + ADDR_W'(gi);
            assign raw_bytes[gi] = mem[lane_addr[gi]];
        end
    endgenerate

    always_comb begin
        lane_en = 4'b1111;
        case (size_reg)
            SIZE_BYTE: lane_en = 4'b0001;
            SIZE_HALF: lane_en = 4'b0011;
            default:   lane_en = 4'b1111;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_reg;

    assign misaligned = ((size_reg == SIZE_HALF) && addr_reg[0]) ||
                        (size_reg[1] && (addr_reg[1:0] != 2'b00));
    assign err_o      = err_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= finish && misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign err_o      = 1'b0;
`endif

    dmem_lane_fmt u_fmt (
        .size     (size_reg),
        .zero_ext (zext_reg),
        .raw      (raw_bytes),
        .result   (fmt_data)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_i) begin
                    cnt_next   = CNT_LOAD;
                    state_next = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            size_reg  <= SIZE_BYTE;
            zext_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            valid_reg <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            valid_reg <= finish;
            if (accept) begin
                we_reg    <= we_i;
                size_reg  <= size_i;
                zext_reg  <= unsigned_i;
                addr_reg  <= addr_i[ADDR_W-1:0];
                wdata_reg <= wdata_i;
            end
            if (finish) begin
                if (misaligned) begin
                    rdata_reg <= '0;
                end else if (!we_reg) begin
                    rdata_reg <= fmt_data;
                end
            end
        end
    end

    // Memory contents survive reset; the rst_i gate blocks a write racing an abort.
    always_ff @(posedge clk_i) begin
        if (finish && we_reg && !misaligned && !rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[lane_addr[i]] <= wdata_reg[8*i +: 8];
                end
            end
        end
    end

    assign ready_o = (state_reg == IDLE);
    assign valid_o = valid_reg;
    assign rdata_o = rdata_reg;

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed, table-driven bench for data_memory_sync (main instance ADDR_W=10, second instance ADDR_W=5).
module tb_data_memory_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        zext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, valid, err;
    logic [31:0] rdata;
    logic        ready_b, valid_b, err_b;
    logic [31:0] rdata_b;

    int checks = 0;
    int failures = 0;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic        ALIGN_ON = 1'b1;
    localparam logic [31:0] MIS_READ = 32'h5566_7788;
`else
    localparam logic        ALIGN_ON = 1'b0;
    localparam logic [31:0] MIS_READ = 32'hF00D_7788;
`endif

    data_memory_sync #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
        .unsigned_i(zext), .addr_i(addr), .wdata_i(wdata),
        .ready_o(ready), .valid_o(valid), .rdata_o(rdata), .err_o(err)
    );

    data_memory_sync #(.ADDR_W(5), .LATENCY(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
        .unsigned_i(zext), .addr_i(addr), .wdata_i(wdata),
        .ready_o(ready_b), .valid_o(valid_b), .rdata_o(rdata_b), .err_o(err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic        z;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One complete access; returns both instances' read data, main err flag and edges to valid.
    task automatic access(input logic w, input logic [1:0] s, input logic z, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic [31:0] rd_b,
                          output logic er, output int lat);
        int busy_ready = 0;
        @(negedge clk);
        check("ready_before_req", {31'b0, ready}, 32'd1);
        req = 1'b1; we = w; size = s; zext = z; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; size = ~s; zext = ~z; addr = ~a; wdata = ~d;
        lat = 0;
        while (!valid && lat < 20) begin
            if (ready) busy_ready++;
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata; rd_b = rdata_b; er = err;
        check("latency", 32'(lat), 32'd2);
        check("ready_low_while_busy", 32'(busy_ready), 32'd0);
        @(posedge clk); #1;
        check("valid_single_pulse", {31'b0, valid}, 32'd0);
        $display("txn we=%0b size=%0d uns=%0b addr=0x%08h wdata=0x%08h rdata=0x%08h rdata_b=0x%08h err=%0b lat=%0d",
                 w, s, z, a, d, rd, rd_b, er, lat);
    endtask

    initial begin
        logic [31:0] rd, rd_b;
        logic        er;
        int          lat;
        int          accepts, pulses, viol;
        int          vc [3];
        logic        pend, ready_pre;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1122_3344, 32'h0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         32'h1122_3344};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_000B, 32'h0,         32'h0000_0011};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0,         32'h0000_3344};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0009, 32'h0,         32'h0000_0033};
        vecs[5]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0,         32'h1122_3344};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0408, 32'h0,         32'h1122_3344};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h1234_5680, 32'h0};
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0,         32'hFFFF_FF80};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0080};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hABCD_8001, 32'h0};
        vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,         32'hFFFF_8001};
        vecs[13] = '{1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_8001};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h8001_0080};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 32'h0000_0023, 32'h0,         32'hFFFF_FF80};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'b0, ready}, 32'd1);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", {31'b0, err}, 32'd0);
        rst = 1'b0;

        // Reset mid-access aborts the write
        access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0102_0304, rd, rd_b, er, lat);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort_accepted", {31'b0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_valid", {31'b0, valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        check("abort_no_valid", 32'(pulses), 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, rd_b, er, lat);
        check("abort_mem_unchanged", rd, 32'h0102_0304);

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            access(vecs[i].w, vecs[i].s, vecs[i].z, vecs[i].a, vecs[i].d, rd, rd_b, er, lat);
            check($sformatf("vec%0d_err", i), {31'b0, er}, 32'd0);
            if (!vecs[i].w) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end

`ifndef DMEM_ALIGN_CHECK_EN
        // Wrap-around at the top of memory in both instances
        access(1'b1, 2'b10, 1'b0, 32'h3FE, 32'hAABB_CCDD, rd, rd_b, er, lat);
        access(1'b0, 2'b00, 1'b1, 32'h3FE, 32'h0, rd, rd_b, er, lat);
        check("wrap_b0", rd, 32'hDD);   check("wrap5_b0", rd_b, 32'hDD);
        access(1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0, rd, rd_b, er, lat);
        check("wrap_b1", rd, 32'hCC);   check("wrap5_b1", rd_b, 32'hCC);
        access(1'b0, 2'b00, 1'b1, 32'h000, 32'h0, rd, rd_b, er, lat);
        check("wrap_b2", rd, 32'hBB);   check("wrap5_b2", rd_b, 32'hBB);
        access(1'b0, 2'b00, 1'b1, 32'h001, 32'h0, rd, rd_b, er, lat);
        check("wrap_b3", rd, 32'hAA);   check("wrap5_b3", rd_b, 32'hAA);
`endif

        // Continuous req for three reads
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; zext = 1'b0; addr = 32'h8;
        accepts = 0; pulses = 0; viol = 0; pend = 1'b0;
        vc[0] = 0; vc[1] = 0; vc[2] = 0;
        for (int c = 1; c <= 12; c++) begin
            ready_pre = ready;
            @(posedge clk); #1;
            if (ready_pre && req) begin
                accepts++;
                pend = 1'b1;
                if (accepts == 3) req = 1'b0;
            end
            if (valid) begin
                if (pulses < 3) vc[pulses] = c;
                pulses++;
                pend = 1'b0;
                check("stream_rdata", rdata, 32'h1122_3344);
            end else if (pend && ready) begin
                viol++;
            end
        end
        $display("txn stream accepts=%0d pulses=%0d at %0d,%0d,%0d", accepts, pulses, vc[0], vc[1], vc[2]);
        check("stream_accepts", 32'(accepts), 32'd3);
        check("stream_pulses", 32'(pulses), 32'd3);
        check("stream_first", 32'(vc[0]), 32'd3);
        check("stream_gap1", 32'(vc[1] - vc[0]), 32'd3);
        check("stream_gap2", 32'(vc[2] - vc[1]), 32'd3);
        check("stream_ready_busy", 32'(viol), 32'd0);

        // Misaligned word write
        access(1'b1, 2'b10, 1'b0, 32'h0, 32'h5566_7788, rd, rd_b, er, lat);
        access(1'b1, 2'b10, 1'b0, 32'h2, 32'hCAFE_F00D, rd, rd_b, er, lat);
        check("misalign_err", {31'b0, er}, {31'b0, ALIGN_ON});
        access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, rd_b, er, lat);
        check("misalign_readback", rd, MIS_READ);
        check("misalign_read_err", {31'b0, er}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_sync.md
Name: data_memory_sync

Overview:
- Clocked, parametrised successor to the single-cycle byte-array data memory in the MEM stage.
- Little-endian byte-addressed RAM supporting byte, half-word and word accesses, with sign/zero extension on reads.
- Configurable access latency; a req/ready/valid handshake lets the pipeline hazard unit stall MEM until the access completes.

Parameters:
- ADDR_W, 10, byte-address bits used; depth = 2**ADDR_W bytes; higher addr_i bits ignored.
- LATENCY, 2, clock edges from request acceptance to valid_o (legal range 1..15).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  1  access request; sampled only while ready_o=1.
- we_i  input  1  1=write, 0=read.
- size_i  input  2  00=byte, 01=half, 10=word, 11=treated as word.
- unsigned_i  input  1  read extension: 1=zero-extend, 0=sign-extend.
- addr_i  input  32  byte address.
- wdata_i  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
- ready_o  output  1  block idle, can accept a request.
- valid_o  output  1  one-cycle pulse: access complete.
- rdata_o  output  32  extended read data, valid while valid_o=1; holds until next completion.
- err_o  output  1  misalignment flag qualified by valid_o (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, ready_o=1, valid_o=0, rdata_o=0, err_o=0, counter=0. Memory contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with req_i=1, latch we_i, size_i, unsigned_i, addr_i[ADDR_W-1:0] and wdata_i, and load counter=LATENCY-1.
  - Go to DONE if LATENCY=1, else WAIT.
  - ready_o=1 only in IDLE.
- WAIT: decrement the counter each edge; go to DONE when the counter reaches 1.
- DONE: on the edge leaving DONE:
  - Write: update the byte lanes selected by size.
  - Read: register rdata_o.
  - valid_o=1 for the following cycle only, then return to IDLE.
  - Net effect: valid_o rises exactly LATENCY edges after the accepting edge. Back-to-back throughput is one access per LATENCY+1 cycles.
- Byte ordering: byte n of the access goes to address (addr+n) mod 2**ADDR_W. Wrap-around past the top of memory continues at address 0.
- Read extension: bit 7 (byte) or bit 15 (half) is replicated into the upper bits unless unsigned_i=1. Word reads are returned unchanged.
- Input changes while not in IDLE are ignored; the latched request is used.
- Reset asserted mid-access aborts the access: no memory write occurs and no valid_o pulse is produced.
- A read following a write to the same address returns the new data; there is no read-during-write hazard because accesses are serialised.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - Misaligned access: memory is untouched, rdata_o=0, err_o=1 together with valid_o. Timing is identical to a normal access.
  - err_o is 0 at all other times.
- Undefined:
  - No check; misaligned accesses are performed byte-wise with wrap-around as above.
  - err_o is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings.
  - FSM state typedef (IDLE/WAIT/DONE).
  - Counter width constant (4 bits).
- One sub-module, dmem_lane_fmt: combinational read formatter taking size, unsigned flag and the 4 raw bytes, producing the 32-bit extended result. It is reused by the future cache fill path.

Test Plan:
- Reset mid-access: assert rst_i one cycle after accepting a word write 0xDEADBEEF to 0x10 -> ready_o=1 and valid_o=0 immediately; a later word read of 0x10 does not return 0xDEADBEEF.
- Word write/read, LATENCY=2: write 0x11223344 to 0x08, then read 0x08 -> valid_o pulses 2 edges after each accept; rdata_o=0x11223344; reading byte 0x0B returns 0x00000011.
- Sign/zero extension: byte write 0x80 to 0x20 -> signed byte read returns 0xFFFFFF80, unsigned returns 0x00000080; half write 0x8001 to 0x22 -> signed half read returns 0xFFFF8001.
- Handshake: hold req_i=1 continuously for three reads -> exactly three valid_o pulses spaced LATENCY+1 cycles apart; ready_o is low between each accept and its valid_o.
- Wrap-around, ADDR_W=5, macro undefined: word write 0xAABBCCDD to 0x1E -> bytes 0x1E=DD, 0x1F=CC, 0x00=BB, 0x01=AA.
- Misalignment, DMEM_ALIGN_CHECK_EN defined: word write to 0x02 -> err_o=1 with valid_o; a subsequent aligned word read of 0x00 shows the previous contents unchanged.
